// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses SYNC, LEN_LO, LEN_HI, payload, CHK frames and writes payload bytes.
// Latency: each accepted payload byte produces its mem_we strobe exactly one cycle later; back-to-back bytes give one write per cycle.
// Backpressure: rx_ready is high in every cycle except the one following a reset cycle; the loader never stalls the link otherwise.
//
// Ports:
//   clk, reset                 : system clock, synchronous active-high reset
//   rx_valid/rx_ready/rx_data  : byte stream from the host link (transfer when valid && ready)
//   mem_we/mem_addr/mem_wdata  : byte write port into the instruction memory
//   cpu_hold                   : keeps the CPU in reset until a frame loads cleanly
//   done/error                 : sticky outcome of the last frame
//   bytes_loaded               : payload bytes written by the current or last frame
module imem_loader #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned BASE_ADDR   = 0,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       bytes_loaded
);

    localparam int unsigned         TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]     TO_LIMIT = TO_W'(TIMEOUT_CYC);
    // Largest payload that fits between BASE_ADDR and the top of memory.
    localparam logic [16:0]         MAX_LEN  = 17'(DEPTH - BASE_ADDR);
    localparam logic [ADDR_W-1:0]   BASE_PTR = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic              rx_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              error_q;
    logic [15:0]       bytes_loaded_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        acc_q;
    logic [TO_W-1:0]   to_q;

    logic              rx_fire;
    logic [15:0]       len_n;
    logic              in_frame;
    logic              last_payload;

    assign rx_fire      = rx_valid && rx_ready_q;
    assign len_n        = {rx_data, len_lo_q};
    // The idle timeout only runs while a frame is partially received.
    assign in_frame     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign last_payload = (bytes_loaded_q == (len_q - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rx_ready_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= BASE_PTR;
            mem_wdata_q    <= 8'h00;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            bytes_loaded_q <= 16'd0;
            len_lo_q       <= 8'h00;
            len_q          <= 16'd0;
            ptr_q          <= BASE_PTR;
            acc_q          <= 8'h00;
            to_q           <= '0;
        end else begin
            rx_ready_q <= 1'b1;
            mem_we_q   <= 1'b0;

            if (in_frame && !rx_fire) begin
                // Link went quiet mid-frame: count idle cycles, abort once the limit is reached.
                if (to_q >= TO_LIMIT) begin
                    state_q <= S_ERR;
                    error_q <= 1'b1;
                    to_q    <= '0;
                end else begin
                    to_q <= to_q + 1'b1;
                end
            end else begin
                to_q <= '0;
                if (rx_fire) begin
                    case (state_q)
                        // DONE and ERR behave like IDLE: only a sync byte does anything.
                        S_IDLE, S_DONE, S_ERR: begin
                            if (rx_data == SYNC_BYTE) begin
                                state_q        <= S_LEN_LO;
                                done_q         <= 1'b0;
                                error_q        <= 1'b0;
                                bytes_loaded_q <= 16'd0;
                                acc_q          <= 8'h00;
                                cpu_hold_q     <= 1'b1;
                            end
                        end
                        S_LEN_LO: begin
                            len_lo_q <= rx_data;
                            state_q  <= S_LEN_HI;
                        end
                        S_LEN_HI: begin
                            len_q <= len_n;
                            // Rejecting oversize frames here is what keeps the pointer from wrapping.
                            if ({1'b0, len_n} > MAX_LEN) begin
                                state_q <= S_ERR;
                                error_q <= 1'b1;
                            end else if (len_n == 16'd0) begin
                                state_q <= S_CHECK;
                            end else begin
                                state_q <= S_PAYLOAD;
                                ptr_q   <= BASE_PTR;
                            end
                        end
                        S_PAYLOAD: begin
                            // A payload byte equal to SYNC_BYTE is plain data here.
                            mem_we_q       <= 1'b1;
                            mem_addr_q     <= ptr_q;
                            mem_wdata_q    <= rx_data;
                            ptr_q          <= ptr_q + 1'b1;
                            acc_q          <= acc_q + rx_data;
                            bytes_loaded_q <= bytes_loaded_q + 16'd1;
                            if (last_payload) begin
                                state_q <= S_CHECK;
                            end
                        end
                        S_CHECK: begin
                            if (rx_data == acc_q) begin
                                state_q    <= S_DONE;
                                done_q     <= 1'b1;
                                cpu_hold_q <= 1'b0;
                            end else begin
                                state_q <= S_ERR;
                                error_q <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // A write registered from the byte accepted just before reset must not reach memory,
    // so the strobe is masked while reset is present.
    assign mem_we       = mem_we_q & ~reset;
    assign rx_ready     = rx_ready_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign bytes_loaded = bytes_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] bytes_loaded;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .bytes_loaded (bytes_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [0:9][7:0] b;
        int              n;
        int              off;
        int              nwr;
        logic            e_done;
        logic            e_err;
        logic            e_hold;
        logic [15:0]     e_loaded;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic [79:0] b, input int n, input int off, input int nwr,
                           input logic d, input logic e, input logic h, input logic [15:0] l);
        tbl[i].b        = b;
        tbl[i].n        = n;
        tbl[i].off      = off;
        tbl[i].nwr      = nwr;
        tbl[i].e_done   = d;
        tbl[i].e_err    = e;
        tbl[i].e_hold   = h;
        tbl[i].e_loaded = l;
    endtask

    // Offer one byte; returns just after the edge on which it transferred.
    task automatic send_byte(input logic [7:0] b, input bit push, input logic [7:0] addr);
        wr_t w;
        int  waits = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) check("rx_ready_wait", 32'(rx_ready), 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (push) begin
            w.addr = addr;
            w.data = b;
            w.cyc  = cyc;
            sb.push_back(w);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h, input logic [15:0] l);
        repeat (3) @(negedge clk);
        check({tag, "_done"},   32'(done),         32'(d));
        check({tag, "_error"},  32'(error),        32'(e));
        check({tag, "_hold"},   32'(cpu_hold),     32'(h));
        check({tag, "_loaded"}, 32'(bytes_loaded), 32'(l));
        check({tag, "_sb_empty"}, 32'(sb.size()),  0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        for (int j = 0; j < v.n; j++) begin
            int idx;
            idx = j - v.off - 3;
            send_byte(v.b[j], (idx >= 0) && (idx < v.nwr), 8'(idx));
        end
        check_status(tag, v.e_done, v.e_err, v.e_hold, v.e_loaded);
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] d;
        int         waits;

        //        bytes (10, zero padded)                                        n  off nwr done err hold loaded
        set_vec(0, {8'hA5,8'h04,8'h00,8'h13,8'h00,8'h00,8'h00,8'h13,8'h00,8'h00}, 8, 0, 4, 1, 0, 0, 16'd4);
        set_vec(1, {8'hA5,8'h04,8'h00,8'h13,8'h00,8'h00,8'h00,8'h14,8'h00,8'h00}, 8, 0, 4, 0, 1, 1, 16'd4);
        set_vec(2, {8'h00,8'hFF,8'hA5,8'h05,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00}, 5, 2, 0, 0, 1, 1, 16'd0);
        set_vec(3, {8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 4, 0, 0, 1, 0, 0, 16'd0);
        set_vec(4, {8'hA5,8'h03,8'h00,8'hA5,8'h01,8'h02,8'hA8,8'h00,8'h00,8'h00}, 7, 0, 3, 1, 0, 0, 16'd3);
        set_vec(5, {8'h5A,8'h33,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 0, 1, 0, 0, 16'd3);
        set_vec(6, {8'hA5,8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0, 0, 0, 1, 1, 16'd0);
        set_vec(7, {8'hA5,8'h01,8'h00,8'h7E,8'h7E,8'h00,8'h00,8'h00,8'h00,8'h00}, 5, 0, 1, 1, 0, 0, 16'd1);
        set_vec(8, {8'hA5,8'h02,8'h00,8'h10,8'h20,8'h31,8'h00,8'h00,8'h00,8'h00}, 6, 0, 2, 0, 1, 1, 16'd2);
        set_vec(9, {8'hA5,8'h02,8'h00,8'hF0,8'h20,8'h10,8'h00,8'h00,8'h00,8'h00}, 6, 0, 2, 1, 0, 0, 16'd2);

        // Write monitor: every strobe must match the oldest expected write, on its expected cycle.
        fork
            forever begin
                wr_t e;
                @(negedge clk);
                if (mem_we === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("unexpected_write", 32'(mem_we), 0);
                    end else begin
                        e = sb.pop_front();
                        check("wr_addr",  32'(mem_addr),  32'(e.addr));
                        check("wr_data",  32'(mem_wdata), 32'(e.data));
                        check("wr_cycle", cyc,            e.cyc);
                    end
                end
            end
        join_none

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready",  32'(rx_ready),     0);
        check("rst_mem_we",    32'(mem_we),       0);
        check("rst_mem_addr",  32'(mem_addr),     0);
        check("rst_mem_wdata", 32'(mem_wdata),    0);
        check("rst_cpu_hold",  32'(cpu_hold),     1);
        check("rst_done",      32'(done),         0);
        check("rst_error",     32'(error),        0);
        check("rst_loaded",    32'(bytes_loaded), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rx_ready", 32'(rx_ready), 1);

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Largest legal frame: 256 payload bytes filling the whole memory.
        sum = 8'h00;
        send_byte(8'hA5, 1'b0, 8'h00);
        send_byte(8'h00, 1'b0, 8'h00);
        send_byte(8'h01, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) begin
            d   = 8'(i * 7 + 3);
            sum = sum + d;
            send_byte(d, 1'b1, 8'(i));
        end
        send_byte(sum, 1'b0, 8'h00);
        check_status("full", 1'b1, 1'b0, 1'b0, 16'd256);

        // Link stalls mid-payload: the byte already written stays, then the frame errors out.
        send_byte(8'hA5, 1'b0, 8'h00);
        send_byte(8'h02, 1'b0, 8'h00);
        send_byte(8'h00, 1'b0, 8'h00);
        send_byte(8'hAA, 1'b1, 8'h00);
        repeat (1000) @(negedge clk);
        check("timeout_early", 32'(error), 0);
        waits = 0;
        while (error !== 1'b1 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check("timeout_err", 32'(error), 1);
        check_status("timeout", 1'b0, 1'b1, 1'b1, 16'd1);
        run_vec(tbl[7], "after_timeout");

        // Reset in the cycle after the 2nd payload byte of a 4-byte frame: that byte is never written.
        send_byte(8'hA5, 1'b0, 8'h00);
        send_byte(8'h04, 1'b0, 8'h00);
        send_byte(8'h00, 1'b0, 8'h00);
        send_byte(8'h11, 1'b1, 8'h00);
        send_byte(8'h22, 1'b0, 8'h00);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_rx_ready",  32'(rx_ready),     0);
        check("mid_rst_mem_we",    32'(mem_we),       0);
        check("mid_rst_mem_addr",  32'(mem_addr),     0);
        check("mid_rst_mem_wdata", 32'(mem_wdata),    0);
        check("mid_rst_cpu_hold",  32'(cpu_hold),     1);
        check("mid_rst_done",      32'(done),         0);
        check("mid_rst_error",     32'(error),        0);
        check("mid_rst_loaded",    32'(bytes_loaded), 0);
        @(negedge clk);
        check("mid_rst_we_after",  32'(mem_we),       0);
        check("mid_rst_ready_after", 32'(rx_ready),   1);

        run_vec(tbl[0], "after_reset");
        run_vec(tbl[8], "bad_chk2");
        run_vec(tbl[9], "wrap_sum");

        repeat (5) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at t=%0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the byte-addressed instruction memory. It receives a framed byte stream over a valid/ready interface and writes payload bytes into consecutive memory locations through a byte write port.
- It checks frame length and an 8-bit additive checksum, and holds the CPU in reset until a frame loads successfully.
- It sits between the host link (UART/debug byte source) and the write side of the instruction memory. The memory read path is unchanged: little-endian 32-bit fetch from byte array.

Parameters:
- DEPTH, 256, instruction memory size in bytes.
- ADDR_W, 8, memory byte-address width; must satisfy 2**ADDR_W >= DEPTH.
- BASE_ADDR, 0, byte address of the first payload byte.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1024, maximum idle cycles between bytes inside a frame; width of timeout counter is $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  byte available from host link.
- rx_data  in  8  byte value; sampled when rx_valid && rx_ready.
- rx_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  one-cycle byte write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte write address.
- mem_wdata  out  8  byte write data.
- cpu_hold  out  1  holds the CPU core (PC/fetch) in reset while high.
- done  out  1  sticky; last frame loaded with matching checksum.
- error  out  1  sticky; last frame failed (length, checksum or timeout).
- bytes_loaded  out  16  payload bytes written in the current or last frame.

Behaviour:
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, N = {LEN_HI,LEN_LO} payload bytes, CHK. CHK = sum of payload bytes mod 256.
- Handshake: a byte transfers on a cycle with rx_valid && rx_ready.
  - rx_ready = 1 in every state except after reset is asserted that cycle, so rx_ready is registered 0 in the reset cycle.
  - rx_data may change freely while rx_valid = 0.
- Reset values: rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0, bytes_loaded=0, state=IDLE, checksum accumulator=0, timeout counter=0.
- States:
  - IDLE: accepted byte == SYNC_BYTE -> LEN_LO, clear done, error, bytes_loaded and the checksum accumulator, and set cpu_hold=1. Any other byte is discarded, and the loader stays in IDLE.
  - LEN_LO: store low length byte -> LEN_HI.
  - LEN_HI: form N.
    - N > DEPTH-BASE_ADDR -> ERR.
    - N == 0 -> CHECK.
    - Otherwise -> PAYLOAD, with the write pointer at BASE_ADDR.
  - PAYLOAD: each accepted byte b at pointer p does the following:
    - Next cycle: mem_we=1, mem_addr=p, mem_wdata=b. Latency is exactly 1 cycle from acceptance to write strobe.
    - Pointer increments; accumulator += b (mod 256); bytes_loaded increments.
    - After the Nth byte -> CHECK.
  - CHECK: accepted byte == accumulator -> DONE, else -> ERR.
  - DONE: done=1, cpu_hold=0. A subsequent SYNC_BYTE starts a new frame (IDLE behaviour); other bytes are ignored.
  - ERR: error=1, cpu_hold stays 1. SYNC_BYTE restarts a frame; other bytes are ignored.
- mem_we is high only the single cycle after each accepted payload byte. Otherwise it is 0; mem_addr and mem_wdata hold their last values.
- Back-to-back bytes (rx_valid high every cycle) produce one write per cycle, with no bubbles.
- Timeout: in LEN_LO, LEN_HI, PAYLOAD and CHECK, the counter increments on each cycle with no accepted byte and clears on acceptance. Reaching TIMEOUT_CYC -> ERR on the next edge. Bytes already written remain in memory.
- A payload byte equal to SYNC_BYTE is data, not a restart.
- Reset mid-frame: abort immediately, return to reset values, and do not issue any pending write. The cycle after reset deasserts, mem_we=0.
- The pointer never exceeds BASE_ADDR+N-1; the length check guarantees there is no wrap.

Test Plan:
- Reset, then frame A5 04 00 13 00 00 00 13 -> writes: addr0=13, addr1=00, addr2=00, addr3=00, one per cycle. Then done=1, cpu_hold=0, bytes_loaded=4, error=0.
- Same frame with CHK=14 -> all 4 writes occur, then error=1, done=0, cpu_hold=1.
- Bytes 00 FF before A5 05 01 -> leading bytes ignored; N=261>256 -> error=1 with no mem_we pulses.
- Frame A5 00 00 00 -> zero payload, no writes, done=1.
- A5 02 00 AA, then rx_valid low for 1024 cycles -> one write (addr0=AA), then error=1. A new frame A5 01 00 7E 7E afterwards -> addr0=7E, done=1, error=0.
- Assert reset for 1 cycle right after the 2nd payload byte of a 4-byte frame is accepted -> no write for that byte. All outputs are at reset values, and cpu_hold=1.
